// File: rtl/tone_decoder.sv
// Tone decoder: measures the period of a square-wave tone, matches it against an
// 8-entry note table and reports the note once it has repeated LOCK_N times.
module tone_decoder #(
  parameter int unsigned P0      = 7644,
  parameter int unsigned P1      = 6811,
  parameter int unsigned P2      = 6067,
  parameter int unsigned P3      = 5727,
  parameter int unsigned P4      = 5102,
  parameter int unsigned P5      = 4545,
  parameter int unsigned P6      = 4050,
  parameter int unsigned P7      = 3822,
  parameter int unsigned TOL     = 64,
  parameter int unsigned LOCK_N  = 3,
  parameter int unsigned TIMEOUT = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [2:0]  note_bin,
  output logic        note_valid,
  output logic        note_change,
  output logic [31:0] period
);

  typedef enum logic [1:0] {StIdle, StMeasure, StTrack} state_e;

  localparam logic [31:0] TimeoutW = 32'(TIMEOUT);
  localparam logic [31:0] TolW     = 32'(TOL);
  localparam logic [3:0]  LockN    = 4'(LOCK_N);
  localparam logic [31:0] PTab [8] = '{32'(P0), 32'(P1), 32'(P2), 32'(P3),
                                       32'(P4), 32'(P5), 32'(P6), 32'(P7)};

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic        s1_q, s2_q, s3_q;
  logic        edge_det, timeout_hit;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic        per_vld_q, per_vld_d;
  logic        hit_q, hit_d;
  logic [2:0]  idx_q, idx_d;
  logic        cmp_vld_q;
  state_e      state_q, state_d;
  logic [2:0]  cand_q, cand_d;
  logic [3:0]  cand_cnt_q, cand_cnt_d;
  logic [2:0]  note_bin_q, note_bin_d;
  logic        note_valid_q, note_valid_d;
  logic        note_change_q, note_change_d;

  assign edge_det = s2_q & ~s3_q;
  // A same-cycle edge reloads the counter, so it takes priority over silence.
  assign timeout_hit = !edge_det && (cnt_q == TimeoutW - 32'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_det) begin
      cnt_d = 32'd1;
    end else if (cnt_q < TimeoutW) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_comb begin
    per_vld_d = edge_det && (state_q != StIdle);
    period_d  = per_vld_d ? cnt_q : period_q;
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit_d = 1'b0;
    idx_d = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (abs_diff(period_q, PTab[k]) <= TolW) begin
        hit_d = 1'b1;
        idx_d = 3'(k);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cand_cnt_d    = cand_cnt_q;
    note_bin_d    = note_bin_q;
    note_valid_d  = note_valid_q;
    note_change_d = 1'b0;
    if (timeout_hit) begin
      state_d      = StIdle;
      note_valid_d = 1'b0;
      cand_cnt_d   = 4'd0;
    end else if (cmp_vld_q) begin
      if (!hit_q) begin
        state_d      = StMeasure;
        cand_cnt_d   = 4'd0;
        note_valid_d = 1'b0;
      end else begin
        if (idx_q == cand_q) begin
          cand_cnt_d = (cand_cnt_q >= LockN) ? LockN : cand_cnt_q + 4'd1;
        end else begin
          cand_d     = idx_q;
          cand_cnt_d = 4'd1;
        end
        if (cand_cnt_d == LockN) begin
          state_d = StTrack;
          if (!note_valid_q || (note_bin_q != cand_d)) begin
            note_bin_d    = cand_d;
            note_valid_d  = 1'b1;
            note_change_d = 1'b1;
          end
        end
      end
    end else if (edge_det && (state_q == StIdle)) begin
      state_d = StMeasure;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      cnt_q         <= 32'd0;
      period_q      <= 32'd0;
      per_vld_q     <= 1'b0;
      hit_q         <= 1'b0;
      idx_q         <= 3'd0;
      cmp_vld_q     <= 1'b0;
      state_q       <= StIdle;
      cand_q        <= 3'd0;
      cand_cnt_q    <= 4'd0;
      note_bin_q    <= 3'd0;
      note_valid_q  <= 1'b0;
      note_change_q <= 1'b0;
    end else begin
      s1_q          <= tone_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      per_vld_q     <= per_vld_d;
      hit_q         <= hit_d;
      idx_q         <= idx_d;
      cmp_vld_q     <= per_vld_q;
      state_q       <= state_d;
      cand_q        <= cand_d;
      cand_cnt_q    <= cand_cnt_d;
      note_bin_q    <= note_bin_d;
      note_valid_q  <= note_valid_d;
      note_change_q <= note_change_d;
    end
  end

  assign note_bin    = note_bin_q;
  assign note_valid  = note_valid_q;
  assign note_change = note_change_q;
  assign period      = period_q;

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
Decodes a square-wave tone back into the 3-bit note code the dds tone generator is driven with. It is the measurement/receive counterpart of dds.
- Measures the tone period in clk cycles and matches it against an 8-entry note-period table.
- Reports the note only after it has been stable for several consecutive periods.
- Sits after any tone source (dds divide_clk or an external pin) and feeds note display/control logic.

Parameters:
P0, 7644, expected full period (clk cycles) of note 0 (C4 at 2 MHz clk)
P1, 6811, note 1 period (D4)
P2, 6067, note 2 period (E4)
P3, 5727, note 3 period (F4)
P4, 5102, note 4 period (G4)
P5, 4545, note 5 period (A4)
P6, 4050, note 6 period (B4)
P7, 3822, note 7 period (C5)
TOL, 64, match tolerance in clk cycles; table gaps must exceed 2*TOL
LOCK_N, 3, consecutive matching periods required to lock or change note (1..15)
TIMEOUT, 16384, cycles without a rising edge before declaring silence

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
tone_in  input  1  asynchronous square-wave tone
note_bin  output  3  decoded note code
note_valid  output  1  note_bin holds a locked note
note_change  output  1  one-cycle pulse when note_bin/note_valid newly lock
period  output  32  last measured full period in clk cycles

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM in IDLE, counters/candidate cleared, synchronizer cleared. Reset has immediate effect mid-operation.
- Input path: 2-FF synchronizer, then a third register for edge detect. A rising edge is detected when stage2=1 and stage3=0.
- Period counter (32b) increments every clk and saturates at TIMEOUT. On an edge cycle it loads 1.
- Measured period = clk-cycle distance between consecutive edge-detect cycles. It is registered into period on the edge cycle, in MEASURE/TRACK only.
- Compare stage: one registered cycle, 8 parallel |period-Pk|<=TOL tests. The lowest matching index wins.
- FSM:
  - IDLE: first edge -> MEASURE. No period is produced.
  - MEASURE: each edge produces a period -> compare. Transition to TRACK when the candidate count reaches LOCK_N.
  - TRACK: same comparison; locked outputs are maintained.
  - Any state: counter reaches TIMEOUT -> IDLE, note_valid=0, candidate count=0. period and note_bin hold.
- Candidate logic per compared period:
  - Match k, k==cand: cand_cnt++ (saturating at LOCK_N).
  - Match k, k!=cand: cand=k, cand_cnt=1.
  - No match: cand_cnt=0, note_valid=0, FSM -> MEASURE.
- Lock: when cand_cnt reaches LOCK_N and (note_valid=0 or note_bin!=cand):
  - note_bin=cand, note_valid=1, note_change=1 for exactly one cycle.
  - A continued identical note gives no further pulse.
- Note switch while locked: note_valid stays 1 with the old note_bin until the new candidate locks (no intermediate drop).
- Latency: note outputs update 4 clk edges after the clk edge that first samples tone_in=1 for the locking rising edge (2 sync + edge/period register + compare register). period updates 2 edges after that sample.
- Simultaneous edge and TIMEOUT saturation in the same cycle: the edge wins, counter loads 1, no timeout.
- Widths: all comparisons 32-bit unsigned. |diff| uses the larger minus the smaller, with no wrap.

Test Plan:
- Reset, then a tone with period 6067 clk (50% duty): after the 4th rising edge + 4 clk, note_bin=2, note_valid=1, one note_change pulse. period=6067. No further pulses over 10 more periods.
- Locked on note 2, switch tone to period 4545: note_bin stays 2 and valid stays 1 for 2 periods. After the 3rd 4545 period, note_bin=5 with one note_change pulse.
- Tolerance: period 6131 (P2+64) locks note 2. Then period 6132 (P2+65): note_valid drops to 0 on the compare cycle of the first 6132 period, no note_change.
- Silence: locked on note 7, tone_in held low: note_valid=0 exactly when the counter reaches 16384 after the last edge. note_bin stays 7, period stays 3822.
- Async reset: assert rst=0 mid-lock between clk edges: outputs 0 immediately. Release, then a 5102-period tone relocks to note 4 after LOCK_N periods.
- Jitter: alternating periods 4540/4550 lock note 5. A single 3000-cycle glitch period clears valid, and 3 good periods relock it with one pulse.
